// File: rtl/sha256_block_ctrl.sv
// SHA-256 block controller.
// Gathers one 512-bit block (16 words) from a valid/ready stream into a local
// buffer, then replays it gap-free into the message schedule while driving
// the hash core's round strobes, IV load and H update. Multi-block messages
// loop back to FILL until a block tagged with in_last completes.
module sha256_block_ctrl #(
  parameter int WORD_W      = 32,
  parameter int BLOCK_WORDS = 16,
  parameter int ROUNDS      = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [WORD_W-1:0] ms_data,
  output logic              ms_write_enable,
  output logic              ms_inner_busy,
  output logic              core_init,
  output logic              core_round_en,
  output logic [5:0]        round_idx,
  output logic              core_update,
  output logic              done,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    RUN   = 3'd2,
    FINAL = 3'd3,
    DONE  = 3'd4
  } state_t;

  // RUN counts 0..ROUNDS inclusive: the extra cycle drains the schedule's
  // one-cycle latency so the last round strobe lines up with cnt==ROUNDS.
  localparam logic [6:0] CNT_LAST  = 7'(ROUNDS);
  localparam logic [6:0] CNT_WR    = 7'(BLOCK_WORDS);
  localparam logic [3:0] WPTR_LAST = 4'(BLOCK_WORDS - 1);

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        wptr;
  logic [6:0]        cnt;
  logic              last_flag;
  logic              accept;
  logic              init_p1;
  logic              round_en_p1;
  logic [5:0]        round_idx_p1;
  logic [WORD_W-1:0] blk_buf [BLOCK_WORDS];

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode and combinational outputs.
  always_comb begin
    state_nxt       = state;
    in_ready        = 1'b0;
    accept          = 1'b0;
    ms_data         = '0;
    ms_write_enable = 1'b0;
    ms_inner_busy   = 1'b0;
    core_update     = 1'b0;
    done            = 1'b0;
    busy            = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) state_nxt = FILL;
      end
      FILL: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid && (wptr == WPTR_LAST)) state_nxt = RUN;
      end
      RUN: begin
        ms_inner_busy = (cnt < CNT_LAST);
        if (cnt < CNT_WR) begin
          ms_write_enable = 1'b1;
          ms_data         = blk_buf[cnt[3:0]];
        end
        if (cnt == CNT_LAST) state_nxt = FINAL;
      end
      FINAL: begin
        core_update = 1'b1;
        state_nxt   = last_flag ? DONE : FILL;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control counters, final-block flag and the schedule-latency pipeline.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr         <= '0;
      cnt          <= '0;
      last_flag    <= 1'b0;
      init_p1      <= 1'b0;
      round_en_p1  <= 1'b0;
      round_idx_p1 <= '0;
    end else begin
      // IV load only on the IDLE->FILL transition, never on later blocks.
      init_p1 <= (state == IDLE) && start;
      if (accept) begin
        wptr <= (wptr == WPTR_LAST) ? 4'd0 : wptr + 4'd1;
        if (wptr == WPTR_LAST) last_flag <= in_last;
      end
      if (state == RUN) cnt <= (cnt == CNT_LAST) ? 7'd0 : cnt + 7'd1;
      else              cnt <= '0;
      // ---- stage p1: schedule output Wt is valid one cycle after its feed
      round_en_p1  <= ms_inner_busy;
      round_idx_p1 <= cnt[5:0];
    end
  end

  // Block buffer; contents need no reset.
  always_ff @(posedge clk) begin
    if (accept) blk_buf[wptr] <= in_data;
  end

  assign core_init     = init_p1;
  assign core_round_en = round_en_p1;
  assign round_idx     = round_idx_p1;

endmodule
